dat_mem_arb: RTL and testbench

Two-port arbiter and sequencer for the single-port 256x8 data memory. It shares the memory between the processor load/store port (port 0) and the loader/DMA port (port 1). It grants at most one access per cycle, using round-robin fairness with optional bounded burst locking. It drives the memory's write enable, address and write data, and registers read data back to the granted requester.

---
 rtl/dat_mem_arb_pkg.sv | 14 +
 rtl/dat_mem_arb_rr_pick2.sv | 14 +
 rtl/dat_mem_arb.sv | 143 ++++++++++++++
 tb/tb_dat_mem_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dat_mem_arb_pkg.sv
// Shared types and default parameters for the data-memory arbiter.
package dat_mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam int AW_DEF        = 8;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/dat_mem_arb_rr_pick2.sv
// Combinational two-way round-robin pick: on a tie the port that was not
// granted last wins; a lone requester always wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,   // 0 = P0 granted last, 1 = P1 granted last
  output logic pick,   // 0 = P0, 1 = P1 (meaningful only when valid)
  output logic valid
);

  assign valid = req0 | req1;
  assign pick  = (req0 & req1) ? ~last : req1;

endmodule

// File: rtl/dat_mem_arb.sv
// Two-port arbiter for the single-port data memory: round-robin with
// bounded burst locking, zero-latency grant, registered read return.
module dat_mem_arb
  import dat_mem_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  localparam int BW = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  owner_e        owner_q, owner_d;
  logic          last_q, last_d;
  logic [BW-1:0] beats_q, beats_d;

  logic rr_pick, rr_valid;
  logic hold0, hold1;
  logic win_vld, win_sel;
  logic win_lock;
  owner_e win_own;
  logic rvalid0_q, rvalid1_q;
  logic [DW-1:0] rdata0_q, rdata1_q;

  rr_pick2 u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .pick  (rr_pick),
    .valid (rr_valid)
  );

  // A locked owner keeps the memory unless the other port has waited through
  // a full burst.
  assign hold0 = (owner_q == OWN_P0) && req0 && (!req1 || (beats_q < BMAX));
  assign hold1 = (owner_q == OWN_P1) && req1 && (!req0 || (beats_q < BMAX));

  // Winner select: burst hold first, round-robin otherwise.
  always_comb begin
    win_vld = rr_valid;
    win_sel = rr_pick;
    if (hold0) begin
      win_vld = 1'b1;
      win_sel = 1'b0;
    end else if (hold1) begin
      win_vld = 1'b1;
      win_sel = 1'b1;
    end
  end

  // Grants are suppressed while reset is asserted so nothing commits.
  assign gnt0 = !reset && win_vld && !win_sel;
  assign gnt1 = !reset && win_vld &&  win_sel;

  // Memory-side mux; everything idles to zero with no winner.
  assign mem_wr_en  = (gnt0 & we0) | (gnt1 & we1);
  assign mem_addr   = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign mem_dat_in = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

  // Owner / last / burst-counter next state.
  always_comb begin
    owner_d  = owner_q;
    last_d   = last_q;
    beats_d  = beats_q;
    win_lock = gnt1 ? lock1 : lock0;
    win_own  = gnt1 ? OWN_P1 : OWN_P0;
    if (((owner_q == OWN_P0) && !req0) || ((owner_q == OWN_P1) && !req1)) begin
      owner_d = OWN_NONE;
      beats_d = '0;
    end
    if (gnt0 || gnt1) begin
      last_d = gnt1;
      if (win_lock) begin
        owner_d = win_own;
        if (owner_q == win_own)
          beats_d = (beats_q < BMAX) ? beats_q + BW'(1) : BMAX;
        else
          beats_d = BW'(1);
      end else begin
        owner_d = OWN_NONE;
        beats_d = '0;
      end
    end
  end

  // Arbitration state register; P1 as "last" lets P0 win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      last_q  <= 1'b1;
      beats_q <= '0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

  // Read return: capture memory output on a granted read beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 & !we0;
      rvalid1_q <= gnt1 & !we1;
      if (gnt0 && !we0) rdata0_q <= mem_dat_out;
      if (gnt1 && !we1) rdata1_q <= mem_dat_out;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_dat_mem_arb.sv
// Directed bench for dat_mem_arb with a behavioural 256x8 memory alongside.
module tb_dat_mem_arb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, we0 = 0, we1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_wr_en;
  logic [7:0] rdata0, rdata1, mem_addr, mem_dat_in, mem_dat_out;
  logic [7:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dat_mem_arb #(.AW(8), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
    .mem_dat_out(mem_dat_out)
  );

  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
  assign mem_dat_out = mem[mem_addr];

  // Mutual exclusion of grants, watched for the whole run.
  always @(negedge clk) begin
    checks++;
    if (gnt0 && gnt1) begin
      errors++;
      $display("FAIL excl_gnt t=%0t got gnt0=1 gnt1=1 exp at most one", $time);
    end
  end

  task automatic idle();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; we0 = 0; we1 = 0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    edge1();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; req0 = 1; we0 = 1; addr0 = 8'd9; wdata0 = 8'h77;
    #1;
    checks += 3;
    if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got %b exp 0", gnt0); end
    if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wren got %b exp 0", mem_wr_en); end
    if ({rvalid0, rvalid1, rdata0, rdata1} !== 18'd0) begin
      errors++; $display("FAIL rst_regs got %b%b %h %h exp all 0", rvalid0, rvalid1, rdata0, rdata1);
    end
    do_reset();
  endtask

  task automatic test_write_read();
    req0 = 1; we0 = 1; addr0 = 8'd60; wdata0 = 8'h10;
    #1;
    checks += 3;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL wr_gnt got %b%b exp 10", gnt0, gnt1); end
    if (mem_wr_en !== 1'b1) begin errors++; $display("FAIL wr_en got %b exp 1", mem_wr_en); end
    if (mem_addr !== 8'd60 || mem_dat_in !== 8'h10) begin
      errors++; $display("FAIL wr_bus got %0d/%h exp 60/10", mem_addr, mem_dat_in);
    end
    edge1();
    checks++;
    if (mem[60] !== 8'h10) begin errors++; $display("FAIL wr_commit got %h exp 10", mem[60]); end
    // Second write used later by the alternation test.
    addr0 = 8'd61; wdata0 = 8'h22;
    edge1();
    we0 = 0; addr0 = 8'd60;
    #1;
    checks++;
    if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b exp 1", gnt0); end
    edge1();
    idle();
    checks += 2;
    if (rvalid0 !== 1'b1) begin errors++; $display("FAIL rd_valid got %b exp 1", rvalid0); end
    if (rdata0 !== 8'h10) begin errors++; $display("FAIL rd_data got %h exp 10", rdata0); end
    edge1();
    checks++;
    if (rvalid0 !== 1'b0) begin errors++; $display("FAIL rd_pulse got %b exp 0", rvalid0); end
  endtask

  task automatic test_alternate();
    do_reset();
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'd60; addr1 = 8'd61;
    for (int c = 0; c < 6; c++) begin
      logic e1;
      e1 = c[0];
      #1;
      checks++;
      if (gnt0 !== !e1 || gnt1 !== e1) begin
        errors++; $display("FAIL alt_gnt c=%0d got %b%b exp %b%b", c, gnt0, gnt1, !e1, e1);
      end
      edge1();
      checks++;
      if (e1 ? (rvalid1 !== 1'b1 || rvalid0 !== 1'b0 || rdata1 !== 8'h22)
             : (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== 8'h10)) begin
        errors++; $display("FAIL alt_rd c=%0d got v=%b%b d=%h/%h", c, rvalid0, rvalid1, rdata0, rdata1);
      end
    end
    idle();
    edge1();
  endtask

  task automatic test_lock1_burst();
    logic exp_p0 [6] = '{0, 0, 0, 0, 1, 0};
    int   exp_a  [6] = '{0, 1, 2, 3, 100, 4};
    logic [7:0] p1a = 0;
    logic p0done = 0;
    logic g0, g1;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req1 = 1; lock1 = 1; we1 = 1; addr1 = p1a; wdata1 = 8'h80 + p1a;
      req0 = (c >= 1) && !p0done; lock0 = 0; we0 = 1; addr0 = 8'd100; wdata0 = 8'h55;
      #1;
      g0 = gnt0; g1 = gnt1;
      checks += 2;
      if (g0 !== exp_p0[c] || g1 !== !exp_p0[c]) begin
        errors++; $display("FAIL burst_gnt c=%0d got %b%b exp %b%b", c, g0, g1, exp_p0[c], !exp_p0[c]);
      end
      if (mem_addr !== 8'(exp_a[c])) begin
        errors++; $display("FAIL burst_addr c=%0d got %0d exp %0d", c, mem_addr, exp_a[c]);
      end
      edge1();
      if (g1) p1a++;
      if (g0) p0done = 1;
    end
    idle();
    for (int a = 0; a < 5; a++) begin
      checks++;
      if (mem[a] !== 8'(8'h80 + a)) begin errors++; $display("FAIL burst_mem a=%0d got %h exp %h", a, mem[a], 8'(8'h80 + a)); end
    end
    checks++;
    if (mem[100] !== 8'h55) begin errors++; $display("FAIL burst_p0mem got %h exp 55", mem[100]); end
    edge1();
  endtask

  task automatic test_lock0_long();
    req0 = 1; lock0 = 1; we0 = 0; addr0 = 8'd60;
    for (int c = 0; c < 10; c++) begin
      int eb;
      eb = (c + 1 < 4) ? c + 1 : 4;
      #1;
      checks++;
      if (gnt0 !== 1'b1) begin errors++; $display("FAIL lock0_gnt c=%0d got %b exp 1", c, gnt0); end
      edge1();
      checks += 2;
      if (rvalid0 !== 1'b1 || rdata0 !== 8'h10) begin
        errors++; $display("FAIL lock0_rd c=%0d got %b/%h exp 1/10", c, rvalid0, rdata0);
      end
      if (int'(dut.beats_q) != eb) begin
        errors++; $display("FAIL lock0_beats c=%0d got %0d exp %0d", c, dut.beats_q, eb);
      end
    end
    // Saturated burst: a newcomer must win immediately.
    req1 = 1; lock1 = 0; we1 = 0; addr1 = 8'd61;
    #1;
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b1) begin errors++; $display("FAIL force_rel got %b%b exp 01", gnt0, gnt1); end
    edge1();
    checks++;
    if (dut.beats_q !== 3'd0) begin errors++; $display("FAIL force_beats got %0d exp 0", dut.beats_q); end
    idle();
    edge1();
  endtask

  task automatic test_reset_mid();
    req1 = 1; we1 = 1; addr1 = 8'd65; wdata1 = 8'h3C;
    edge1();
    we1 = 0;
    #1;
    checks++;
    if (gnt1 !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b exp 1", gnt1); end
    edge1();
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== 8'h3C) begin errors++; $display("FAIL mid_rd got %b/%h exp 1/3c", rvalid1, rdata1); end
    reset = 1;
    #1;
    checks += 2;
    if (rvalid1 !== 1'b0 || rdata1 !== 8'h00) begin errors++; $display("FAIL mid_clr got %b/%h exp 0/00", rvalid1, rdata1); end
    if (gnt1 !== 1'b0) begin errors++; $display("FAIL mid_gntrst got %b exp 0", gnt1); end
    edge1();
    reset = 0;
    req0 = 1; we0 = 0; addr0 = 8'd60;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL mid_tie got %b%b exp 10", gnt0, gnt1); end
    idle();
    edge1();
  endtask

  task automatic test_back_to_back();
    req1 = 1; we1 = 1; addr1 = 8'd200; wdata1 = 8'hA5;
    #1;
    checks++;
    if (gnt1 !== 1'b1 || mem_wr_en !== 1'b1) begin errors++; $display("FAIL raw_wr got %b/%b exp 1/1", gnt1, mem_wr_en); end
    edge1();
    idle();
    req0 = 1; we0 = 0; addr0 = 8'd200;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || mem_addr !== 8'd200) begin errors++; $display("FAIL raw_gnt got %b/%0d exp 1/200", gnt0, mem_addr); end
    edge1();
    idle();
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== 8'hA5) begin errors++; $display("FAIL raw_data got %b/%h exp 1/a5", rvalid0, rdata0); end
    edge1();
    checks++;
    if (mem_wr_en !== 1'b0 || mem_addr !== 8'd0 || mem_dat_in !== 8'd0) begin
      errors++; $display("FAIL idle_bus got %b/%0d/%h exp 0/0/00", mem_wr_en, mem_addr, mem_dat_in);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_lock1_burst();
    test_lock0_long();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
